// File: rtl/io_csr_bank.sv
// io_csr_bank: Avalon-MM slave register bank in front of the port-capture array.
// Holds array configuration, reads back capture bits, generates one-cycle
// clear pulses and keeps a sticky, software-clearable interrupt status bit.
// Optional feature macro: IO_EVENT_COUNT_EN adds one saturating 16-bit
// rising-edge counter per port at word addresses 0x10 + i.
module io_csr_bank #(
    parameter int NUM_PORTS  = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic                   write,
    input  logic [DATA_WIDTH-1:0]  writedata,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  readdata,
    output logic                   readdatavalid,
    input  logic [NUM_PORTS-1:0]   capture_in,
    input  logic                   irq_in,
    output logic                   enable,
    output logic [NUM_PORTS-1:0]   clr,
    output logic [NUM_PORTS-1:0]   en_noise_cancelling,
    output logic [NUM_PORTS-1:0]   interrupt_mask,
    output logic [2*NUM_PORTS-1:0] select_edge,
    output logic [2*NUM_PORTS-1:0] select_interrupt,
    output logic                   irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(32'd0);
    localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(32'd1);
    localparam logic [ADDR_WIDTH-1:0] A_CLR    = ADDR_WIDTH'(32'd2);
    localparam logic [ADDR_WIDTH-1:0] A_NOISE  = ADDR_WIDTH'(32'd3);
    localparam logic [ADDR_WIDTH-1:0] A_IMASK  = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] A_EDGE   = ADDR_WIDTH'(32'd5);
    localparam logic [ADDR_WIDTH-1:0] A_ISEL   = ADDR_WIDTH'(32'd6);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(32'd7);

    logic                   en_r;
    logic                   irq_en_r;
    logic [NUM_PORTS-1:0]   clr_r;
    logic [NUM_PORTS-1:0]   noise_r;
    logic [NUM_PORTS-1:0]   imask_r;
    logic [2*NUM_PORTS-1:0] edge_r;
    logic [2*NUM_PORTS-1:0] isel_r;
    logic                   irq_in_d_r;
    logic                   irq_pend_r;
    logic                   irq_r;
    logic [DATA_WIDTH-1:0]  readdata_r;
    logic                   readdatavalid_r;
    logic [DATA_WIDTH-1:0]  rd_data_s;
    logic                   irq_rise_s;
    logic                   status_clr_s;
    logic                   unused_wdata_s;

    // Only the low writedata bits of each register are meaningful.
    assign unused_wdata_s = ^writedata;

    assign irq_rise_s   = irq_in & ~irq_in_d_r;
    assign status_clr_s = write & (address == A_STATUS) & writedata[0];

`ifdef IO_EVENT_COUNT_EN
    logic [NUM_PORTS-1:0] cap_d_r;
    logic [NUM_PORTS-1:0] cap_rise_s;
    logic [15:0]          cnt_r [NUM_PORTS];

    assign cap_rise_s = capture_in & ~cap_d_r;

    // Per-port rising-edge counters; a write clears, a coincident rise leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_d_r <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else begin
            cap_d_r <= capture_in;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((32'd16 + 32'(i)) >= (32'd1 << ADDR_WIDTH)) begin
                    cnt_r[i] <= 16'h0000;
                end else if (write && (address == ADDR_WIDTH'(32'd16 + 32'(i)))) begin
                    cnt_r[i] <= {15'h0000, cap_rise_s[i]};
                end else if (cap_rise_s[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'h0001;
                end
            end
        end
    end
`endif

    // Configuration registers and one-cycle clear pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            clr_r    <= '0;
            noise_r  <= '0;
            imask_r  <= '0;
            edge_r   <= '0;
            isel_r   <= '0;
        end else begin
            clr_r <= '0;
            if (write) begin
                case (address)
                    A_CTRL: begin
                        en_r     <= writedata[0];
                        irq_en_r <= writedata[1];
                    end
                    A_CLR:   clr_r   <= writedata[NUM_PORTS-1:0];
                    A_NOISE: noise_r <= writedata[NUM_PORTS-1:0];
                    A_IMASK: imask_r <= writedata[NUM_PORTS-1:0];
                    A_EDGE:  edge_r  <= writedata[2*NUM_PORTS-1:0];
                    A_ISEL:  isel_r  <= writedata[2*NUM_PORTS-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Sticky interrupt status: rising edge of irq_in sets, W1C clears, set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_in_d_r <= 1'b0;
            irq_pend_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_in_d_r <= irq_in;
            irq_pend_r <= irq_rise_s | (irq_pend_r & ~status_clr_s);
            irq_r      <= irq_pend_r & irq_en_r;
        end
    end

    // Read mux over pre-write state; unmapped addresses read zero.
    always_comb begin
        rd_data_s = '0;
        case (address)
            A_CTRL:   rd_data_s[1:0]             = {irq_en_r, en_r};
            A_DATA:   rd_data_s[NUM_PORTS-1:0]   = capture_in;
            A_NOISE:  rd_data_s[NUM_PORTS-1:0]   = noise_r;
            A_IMASK:  rd_data_s[NUM_PORTS-1:0]   = imask_r;
            A_EDGE:   rd_data_s[2*NUM_PORTS-1:0] = edge_r;
            A_ISEL:   rd_data_s[2*NUM_PORTS-1:0] = isel_r;
            A_STATUS: rd_data_s[0]               = irq_pend_r;
            default: begin
                rd_data_s = '0;
`ifdef IO_EVENT_COUNT_EN
                for (int i = 0; i < NUM_PORTS; i++) begin
                    rd_data_s[15:0] = rd_data_s[15:0] |
                        ((((32'd16 + 32'(i)) < (32'd1 << ADDR_WIDTH)) &&
                          (address == ADDR_WIDTH'(32'd16 + 32'(i)))) ? cnt_r[i] : 16'h0000);
                end
`endif
            end
        endcase
    end

    // Fixed one-cycle read latency; readdata is zero whenever not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_r      <= '0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= read;
            readdata_r      <= read ? rd_data_s : '0;
        end
    end

    assign readdata            = readdata_r;
    assign readdatavalid       = readdatavalid_r;
    assign enable              = en_r;
    assign clr                 = clr_r;
    assign en_noise_cancelling = noise_r;
    assign interrupt_mask      = imask_r;
    assign select_edge         = edge_r;
    assign select_interrupt    = isel_r;
    assign irq                 = irq_r;

endmodule

// File: tb/tb_io_csr_bank.sv
// Directed self-checking bench for io_csr_bank (default parameters).
module tb_io_csr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [11:0] capture_in;
    logic        irq_in;
    logic        enable;
    logic [11:0] clr;
    logic [11:0] en_noise_cancelling;
    logic [11:0] interrupt_mask;
    logic [23:0] select_edge;
    logic [23:0] select_interrupt;
    logic        irq;

    int total = 0;
    int bad   = 0;

    io_csr_bank #(.NUM_PORTS(12), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .readdatavalid(readdatavalid), .capture_in(capture_in), .irq_in(irq_in),
        .enable(enable), .clr(clr), .en_noise_cancelling(en_noise_cancelling),
        .interrupt_mask(interrupt_mask), .select_edge(select_edge),
        .select_interrupt(select_interrupt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; each step ends on the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        step();
        write = 1'b0; writedata = 32'h0;
    endtask

    task automatic do_read(input logic [4:0] a, input string tag, input logic [31:0] exp);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        chk({tag, "_rdv"}, {31'h0, readdatavalid}, 32'h1);
        chk(tag, readdata, exp);
    endtask

    initial begin
        rst = 1'b1; address = 5'h0; write = 1'b0; writedata = 32'h0;
        read = 1'b0; capture_in = 12'h000; irq_in = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_enable", {31'h0, enable}, 32'h0);
        chk("rst_edge", {8'h0, select_edge}, 32'h0);
        chk("rst_clr", {20'h0, clr}, 32'h0);

        // Back-to-back reads of the whole register map.
        for (int a = 0; a < 8; a++) begin
            address = 5'(a); read = 1'b1;
            step();
            chk("b2b_rdv", {31'h0, readdatavalid}, 32'h1);
            chk("b2b_rd", readdata, 32'h0);
        end
        read = 1'b0;
        step();
        chk("idle_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("idle_rd", readdata, 32'h0);

        // EDGE write/readback.
        do_write(5'h05, 32'h00AA_5555);
        chk("edge_out", {8'h0, select_edge}, 32'h00AA_5555);
        do_read(5'h05, "edge_rd", 32'h00AA_5555);

        // CLR pulse: exactly one cycle.
        do_write(5'h02, 32'h0000_0805);
        chk("clr_pulse", {20'h0, clr}, 32'h805);
        step();
        chk("clr_back0", {20'h0, clr}, 32'h0);
        do_read(5'h02, "clr_rd", 32'h0);

        // Read and write together return pre-write data.
        address = 5'h03; writedata = 32'hFFFF_FFFF; write = 1'b1; read = 1'b1;
        step();
        write = 1'b0; read = 1'b0;
        chk("rw_pre", readdata, 32'h0);
        chk("noise_out", {20'h0, en_noise_cancelling}, 32'hFFF);
        do_read(5'h03, "noise_rd", 32'h0000_0FFF);

        do_write(5'h04, 32'h0000_0A5A);
        chk("imask_out", {20'h0, interrupt_mask}, 32'hA5A);
        do_write(5'h06, 32'hFF12_3456);
        chk("isel_out", {8'h0, select_interrupt}, 32'h0012_3456);
        do_read(5'h06, "isel_rd", 32'h0012_3456);

        // Unmapped addresses.
        do_write(5'h08, 32'hDEAD_BEEF);
        do_read(5'h08, "unmap_rd", 32'h0);
        do_read(5'h1F, "unmap1f_rd", 32'h0);

        // Interrupt path.
        do_write(5'h00, 32'h0000_0003);
        chk("ctrl_en", {31'h0, enable}, 32'h1);
        do_read(5'h00, "ctrl_rd", 32'h3);
        irq_in = 1'b1;
        step();
        chk("irq_lat1", {31'h0, irq}, 32'h0);
        step();
        chk("irq_set", {31'h0, irq}, 32'h1);
        step();
        irq_in = 1'b0;
        do_read(5'h07, "stat_rd1", 32'h1);
        step();
        irq_in = 1'b1;
        do_write(5'h07, 32'h0000_0001);
        do_read(5'h07, "stat_setwins", 32'h1);
        chk("irq_hold", {31'h0, irq}, 32'h1);
        do_write(5'h07, 32'h0000_0001);
        do_read(5'h07, "stat_cleared", 32'h0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        irq_in = 1'b0;

        // Capture readback.
        capture_in = 12'h123;
        do_read(5'h01, "data_rd", 32'h0000_0123);

`ifdef IO_EVENT_COUNT_EN
        do_write(5'h10, 32'h0);
        do_read(5'h10, "cnt_clr", 32'h0);
        for (int k = 0; k < 5; k++) begin
            capture_in[0] = 1'b0; step();
            capture_in[0] = 1'b1; step();
        end
        do_read(5'h10, "cnt5", 32'h5);
        capture_in[0] = 1'b0; step();
        capture_in[0] = 1'b1;
        do_write(5'h10, 32'h0);
        do_read(5'h10, "cnt_wr_rise", 32'h1);
`endif

        // Reset during a read: access dropped, state cleared.
        address = 5'h05; read = 1'b1; rst = 1'b1;
        step();
        read = 1'b0; rst = 1'b0;
        chk("rstmid_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("rstmid_rd", readdata, 32'h0);
        chk("rstmid_edge", {8'h0, select_edge}, 32'h0);
        chk("rstmid_en", {31'h0, enable}, 32'h0);
        chk("rstmid_noise", {20'h0, en_noise_cancelling}, 32'h0);
        chk("rstmid_imask", {20'h0, interrupt_mask}, 32'h0);
        chk("rstmid_isel", {8'h0, select_interrupt}, 32'h0);
        step();
        chk("rstmid_rdv2", {31'h0, readdatavalid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
